// File: rtl/itlb_micro_pkg.sv
// Shared cpu definitions for the instruction micro-TLB and its neighbours.
package itlb_micro_pkg;

    // VA[31:30] prefix of the unmapped kseg0/kseg1 window.
    localparam logic [1:0]  KSEG_UNMAPPED = 2'b10;

    // Fetch comes out of reset at the boot vector; the translation-prediction
    // stage resets to the same values so both agree on the first fetch.
    localparam logic [31:0] RESET_PPC  = 32'h1fc0_0000;
    localparam logic [15:0] RESET_MASK = 16'hffff;

    // One cached translation. mask bit = 1 marks VA[27:12] bit as page offset.
    typedef struct packed {
        logic        valid;
        logic        glob;
        logic [7:0]  asid;
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic [15:0] mask;
    } itlb_entry_t;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } itlb_state_e;

endpackage

// File: rtl/itlb_entry_match.sv
// Single-entry comparator and translator; purely combinational.
module itlb_entry_match
    import itlb_micro_pkg::*;
(
    input  itlb_entry_t  entry_i,
    input  logic [31:0]  vpc_i,
    input  logic [7:0]   asid_i,
    output logic         hit_o,
    output logic [31:0]  ppc_o
);

    logic asid_ok;
    logic vpn_ok;

    assign asid_ok = entry_i.glob || (asid_i == entry_i.asid);
    // VA[31:28] always compares exactly; VA[27:12] compares only where the
    // mask says the bit belongs to the page number.
    assign vpn_ok  = (vpc_i[31:28] == entry_i.vpn[19:16]) &&
                     (((vpc_i[27:12] ^ entry_i.vpn[15:0]) & ~entry_i.mask) == 16'h0000);
    assign hit_o   = entry_i.valid && asid_ok && vpn_ok;

    assign ppc_o   = {entry_i.pfn[19:16],
                      (entry_i.pfn[15:0] & ~entry_i.mask) | (vpc_i[27:12] & entry_i.mask),
                      vpc_i[11:0]};

endmodule

// File: rtl/itlb_micro.sv
// Instruction micro-TLB: fully-associative lookup, kseg bypass, refill FSM.
module itlb_micro
    import itlb_micro_pkg::*;
#(
    parameter int ENTRIES = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] vpc,
    input  logic [7:0]  asid,
    input  logic        inval,
    output logic [31:0] ppc_out,
    output logic [15:0] page_mask,
    output logic        fault,
    output logic        miss,
    output logic        refill_req,
    output logic [19:0] refill_vpn,
    input  logic        refill_ack,
    input  logic [19:0] refill_pfn,
    input  logic [15:0] refill_mask,
    input  logic        refill_valid,
    input  logic        refill_global
);

    localparam int VW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    itlb_entry_t        entries_q [ENTRIES];
    logic [VW-1:0]      victim_q;
    itlb_state_e        state_q, state_d;
    logic [19:0]        vpn_q, vpn_d;
    logic [31:0]        ppc_q;
    logic [15:0]        mask_q;
    logic               fault_q;

    logic [ENTRIES-1:0] hit_vec;
    logic [31:0]        ent_ppc [ENTRIES];
    logic               unmapped;
    logic               hit;
    logic [31:0]        sel_ppc;
    logic [15:0]        sel_mask;
    logic               fill_we;
    logic               fault_rsv;

    assign unmapped = (vpc[31:30] == KSEG_UNMAPPED);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_match
        itlb_entry_match u_match (
            .entry_i (entries_q[g]),
            .vpc_i   (vpc),
            .asid_i  (asid),
            .hit_o   (hit_vec[g]),
            .ppc_o   (ent_ppc[g])
        );
    end

    // Priority select: scan high to low so the lowest hitting index wins.
    always_comb begin
        hit      = 1'b0;
        sel_ppc  = '0;
        sel_mask = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit      = 1'b1;
                sel_ppc  = ent_ppc[i];
                sel_mask = entries_q[i].mask;
            end
        end
    end

    // Next-state: a mapped miss starts a refill; any ack ends it. A valid
    // fill is dropped if an invalidate lands on the same cycle.
    always_comb begin
        state_d   = state_q;
        vpn_d     = vpn_q;
        fill_we   = 1'b0;
        fault_rsv = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (!unmapped && !hit) begin
                    state_d = REFILL;
                    vpn_d   = vpc[31:12];
                end
            end
            REFILL: begin
                if (refill_ack) begin
                    state_d   = LOOKUP;
                    fill_we   = refill_valid && !inval;
                    fault_rsv = !refill_valid;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    // An invalid-entry ack is resolved right away as a fault, so fetch is
    // released on that cycle instead of retrying a lookup that cannot hit.
    assign miss = (state_q == REFILL) ? !fault_rsv : (!unmapped && !hit);

    // FSM state and latched refill VPN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOOKUP;
            vpn_q   <= '0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
        end
    end

    // Entry array and round-robin victim pointer; inval never moves the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
            victim_q <= '0;
        end else begin
            if (fill_we) begin
                entries_q[victim_q] <= itlb_entry_t'{valid: 1'b1,
                                                     glob:  refill_global,
                                                     asid:  asid,
                                                     vpn:   vpn_q,
                                                     pfn:   refill_pfn,
                                                     mask:  refill_mask};
                victim_q <= victim_q + VW'(1);
            end
            if (inval) begin
                for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
            end
        end
    end

    // Output registers advance only when fetch is neither stalled nor missing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ppc_q   <= RESET_PPC;
            mask_q  <= RESET_MASK;
            fault_q <= 1'b0;
        end else if (!stall && !miss) begin
            if (fault_rsv) begin
                ppc_q   <= {vpc[31:12], 12'h000};
                mask_q  <= '0;
                fault_q <= 1'b1;
            end else if (unmapped) begin
                ppc_q   <= {3'b000, vpc[28:0]};
                mask_q  <= 16'hffff;
                fault_q <= 1'b0;
            end else begin
                ppc_q   <= sel_ppc;
                mask_q  <= sel_mask;
                fault_q <= 1'b0;
            end
        end
    end

    assign ppc_out    = ppc_q;
    assign page_mask  = mask_q;
    assign fault      = fault_q;
    assign refill_req = (state_q == REFILL);
    assign refill_vpn = vpn_q;

endmodule

// File: doc/itlb_micro.md
# itlb_micro

Instruction-side micro-TLB for the fetch stage. It translates the fetch virtual PC into the registered physical PC and page mask that feed the fetch translation-prediction stage. It holds a small fully-associative cache of translations and bypasses the unmapped kseg0/kseg1 segments. On a miss it stalls fetch and runs a request/acknowledge refill from the main TLB.

## Interface
- ENTRIES, 4, number of fully-associative entries; power of two, 2..8.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; while high, output registers hold.
- vpc  in  32  fetch virtual PC.
- asid  in  8  current address-space ID.
- inval  in  1  one-cycle pulse: invalidate all entries (TLB write, ASID change).
- ppc_out  out  32  registered physical PC.
- page_mask  out  16  registered page mask; 1 = offset bit for VA[27:12].
- fault  out  1  registered; the translation in ppc_out is invalid (TLB invalid entry).
- miss  out  1  combinational stall request to fetch.
- refill_req  out  1  refill request to the main TLB.
- refill_vpn  out  20  VA[31:12] being refilled, held while refill_req is high.
- refill_ack  in  1  one-cycle refill response strobe.
- refill_pfn  in  20  PA[31:12] of the returned page.
- refill_mask  in  16  page mask of the returned page.
- refill_valid  in  1  returned entry is valid.
- refill_global  in  1  returned entry ignores ASID.

## Operation
- **Entry fields:** valid, global, asid[7:0], vpn[19:0], pfn[19:0], mask[15:0].
- **Hit condition:** valid && (global || asid == entry.asid) && vpc[31:28] == vpn[19:16] && ((vpc[27:12] ^ vpn[15:0]) & ~mask) == 0.
  - With multiple hits, the lowest index wins.
- **Translation:**
  - ppc[31:28] = pfn[19:16].
  - ppc[27:12] = (pfn[15:0] & ~mask) | (vpc[27:12] & mask).
  - ppc[11:0] = vpc[11:0].
- **Unmapped:** when vpc[31:30] == 2'b10, the access always hits; ppc = {3'b000, vpc[28:0]} and mask = 16'hffff.
- **FSM states:** LOOKUP and REFILL.
  - LOOKUP, mapped access with no hit → REFILL. The FSM latches refill_vpn = vpc[31:12] and asserts refill_req from the next cycle.
  - REFILL, refill_ack with refill_valid = 1 → write the entry at the victim pointer with asid = current asid; the victim pointer increments mod ENTRIES. Next state LOOKUP, where the lookup retries and hits.
  - REFILL, refill_ack with refill_valid = 0 → no write. The next output update carries fault = 1 with ppc_out = {vpc[31:12], 12'h000}. Next state LOOKUP.
- **Fault persistence:** the fault entry is not cached, so the same vpc faults again on every access until fetch redirects.
- **miss:** miss = (state == REFILL) || (state == LOOKUP && mapped && !hit), except on the cycle a refill_valid = 0 ack resolves the fault, when miss = 0.
- **inval:**
  - inval clears every valid bit in the same cycle.
  - If inval coincides with refill_ack, the fill is discarded and the FSM returns to LOOKUP, where it re-misses.
  - inval does not reset the victim pointer.
- The stall input does not gate the FSM or refills. It only gates the output registers.

## Timing
- **Reset values:** ppc_out = 32'h1fc00000, page_mask = 16'hffff, fault = 0, refill_req = 0, refill_vpn = 0, state LOOKUP, all entries invalid, victim pointer 0.
- **Latency:**
  - Hit: vpc in cycle N → ppc_out/page_mask in cycle N+1, provided stall = 0 and miss = 0 in cycle N.
  - Miss: the output registers do not update while miss = 1.
- **Refill timing:**
  - refill_req rises in cycle N+1 after a miss in cycle N and stays high until refill_ack is sampled.
  - refill_ack must not arrive before refill_req.
  - Minimum miss penalty is 3 cycles (request, ack, retry).
- **Reset mid-refill:** refill_req drops asynchronously and the main TLB must discard the outstanding request.

## Structure
- **Shared cpu package:** entry struct; KSEG_UNMAPPED prefix 2'b10; reset constants RESET_PPC = 32'h1fc00000 and RESET_MASK = 16'hffff. The fetch translation-prediction stage uses the same reset constants.
- **Sub-module:** itlb_entry_match — a single combinational entry comparator and translator, instantiated ENTRIES times. The FSM, priority select and victim pointer stay in the top module.

## Test plan
- **Reset and unmapped:** release reset, vpc = 32'hbfc00004 → ppc_out = 32'h1fc00004, page_mask = 16'hffff next cycle, miss never asserts.
- **Cold miss and refill:**
  - Stimulus: vpc = 32'h00400010, asid = 5; ack after 2 cycles with pfn = 20'h01234, mask = 0, valid = 1, global = 0.
  - Response: refill_vpn = 20'h00400; ppc_out = 32'h01234010 one cycle after the retry.
  - Then asid = 6 with the same vpc → miss again.
- **Large page:** fill with mask = 16'h00ff, pfn = 20'h08000; vpc = 32'h000ab123 → ppc_out = 32'h080ab123.
- **Invalid entry:** ack with refill_valid = 0 for vpc = 32'h00500000 → fault = 1, ppc_out = 32'h00500000, miss drops.
- **Replacement and invalidate:**
  - Fill 5 distinct pages with ENTRIES = 4 → the first page misses again (round-robin wrap).
  - Pulse inval in the same cycle as refill_ack → the page is not cached and the access re-misses.
- **Stall:** hold stall = 1 while vpc changes → ppc_out frozen; refill handshake still completes under stall.
